// File: rtl/instruction_fetch.sv
// RV32I instruction fetch stage: one-outstanding imem requests, BTB next-PC prediction,
// and the IF/ID register with decode stalls and execute-stage redirects.
module instruction_fetch #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        load_stall_i,
    input  logic        peripheral_stall_i,
    input  logic        branching_i,
    input  logic [31:0] branch_target_i,
    input  logic        btb_update_i,
    input  logic [31:0] btb_update_pc_i,
    input  logic [31:0] btb_update_target_i,
    input  logic        btb_update_taken_i,
    output logic [31:0] fetched_instruction_if_o,
    output logic [31:0] pc_if_o,
    output logic [31:0] btb_predicted_pc_if_o,
    output logic        branch_is_taken_prediction_if_o
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] discard_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] hold_pred_pc;
    logic        hold_pred_taken;
    logic        stall;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic             pred_taken;
    logic [31:0]      pred_pc;

    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             unused_upd_bits;

    assign stall = load_stall_i | peripheral_stall_i;

    assign look_idx   = fetch_pc[IDX+1:2];
    assign look_tag   = fetch_pc[31:IDX+2];
    assign look_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    assign pred_taken = look_hit && btb_ctr[look_idx][1];
    assign pred_pc    = pred_taken ? btb_target[look_idx] : fetch_pc + 32'd4;

    assign upd_idx         = btb_update_pc_i[IDX+1:2];
    assign upd_tag         = btb_update_pc_i[31:IDX+2];
    assign upd_hit         = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign unused_upd_bits = ^btb_update_pc_i[1:0];

    // A request is abandoned the instant reset rises; DISCARD keeps presenting the old address.
    assign imem_req_o  = !rst_i && (state != HOLD);
    assign imem_addr_o = (state == DISCARD) ? discard_addr : fetch_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                           <= FETCH;
            fetch_pc                        <= RESET_PC;
            discard_addr                    <= RESET_PC;
            hold_instr                      <= NOP;
            hold_pc                         <= 32'hFFFF_FFFC;
            hold_pred_pc                    <= 32'h0;
            hold_pred_taken                 <= 1'b0;
            fetched_instruction_if_o        <= NOP;
            pc_if_o                         <= 32'hFFFF_FFFC;
            btb_predicted_pc_if_o           <= 32'h0;
            branch_is_taken_prediction_if_o <= 1'b0;
        end else if (branching_i) begin
            fetched_instruction_if_o        <= NOP;
            branch_is_taken_prediction_if_o <= 1'b0;
            fetch_pc                        <= branch_target_i;
            if (state != HOLD && !imem_ack_i) begin
                state        <= DISCARD;
                discard_addr <= imem_addr_o;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack_i) begin
                        fetch_pc <= pred_pc;
                        if (stall) begin
                            hold_instr      <= imem_rdata_i;
                            hold_pc         <= fetch_pc;
                            hold_pred_pc    <= pred_pc;
                            hold_pred_taken <= pred_taken;
                            state           <= HOLD;
                        end else begin
                            fetched_instruction_if_o        <= imem_rdata_i;
                            pc_if_o                         <= fetch_pc;
                            btb_predicted_pc_if_o           <= pred_pc;
                            branch_is_taken_prediction_if_o <= pred_taken;
                        end
                    end else if (!stall) begin
                        fetched_instruction_if_o        <= NOP;
                        branch_is_taken_prediction_if_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fetched_instruction_if_o        <= hold_instr;
                        pc_if_o                         <= hold_pc;
                        btb_predicted_pc_if_o           <= hold_pred_pc;
                        branch_is_taken_prediction_if_o <= hold_pred_taken;
                        state                           <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ack_i) begin
                        state <= FETCH;
                    end
                    if (!stall) begin
                        fetched_instruction_if_o        <= NOP;
                        branch_is_taken_prediction_if_o <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btb_valid <= '0;
        end else if (btb_update_i && !upd_hit && btb_update_taken_i) begin
            btb_valid[upd_idx] <= 1'b1;
        end
    end

    // Hits train the counter; a taken miss replaces whatever occupies the slot.
    always_ff @(posedge clk_i) begin
        if (btb_update_i) begin
            if (upd_hit) begin
                if (btb_update_taken_i) begin
                    btb_target[upd_idx] <= btb_update_target_i;
                    if (btb_ctr[upd_idx] != 2'b11) begin
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                    end
                end else if (btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                end
            end else if (btb_update_taken_i) begin
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= btb_update_target_i;
                btb_ctr[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a scoreboard queue of expected IF/ID entries
// drained by a monitor, plus point checks on the imem bus and IF/ID register.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        taken;
    } exp_t;

    logic        clk_i, rst_i;
    logic        imem_req_o, imem_ack_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        load_stall_i, peripheral_stall_i, branching_i;
    logic [31:0] branch_target_i;
    logic        btb_update_i, btb_update_taken_i;
    logic [31:0] btb_update_pc_i, btb_update_target_i;
    logic [31:0] fetched_instruction_if_o, pc_if_o, btb_predicted_pc_if_o;
    logic        branch_is_taken_prediction_if_o;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    bit   mem_en;
    int   mem_wait;
    int   wait_cnt;

    instruction_fetch dut (
        .clk_i                           (clk_i),
        .rst_i                           (rst_i),
        .imem_req_o                      (imem_req_o),
        .imem_addr_o                     (imem_addr_o),
        .imem_ack_i                      (imem_ack_i),
        .imem_rdata_i                    (imem_rdata_i),
        .load_stall_i                    (load_stall_i),
        .peripheral_stall_i              (peripheral_stall_i),
        .branching_i                     (branching_i),
        .branch_target_i                 (branch_target_i),
        .btb_update_i                    (btb_update_i),
        .btb_update_pc_i                 (btb_update_pc_i),
        .btb_update_target_i             (btb_update_target_i),
        .btb_update_taken_i              (btb_update_taken_i),
        .fetched_instruction_if_o        (fetched_instruction_if_o),
        .pc_if_o                         (pc_if_o),
        .btb_predicted_pc_if_o           (btb_predicted_pc_if_o),
        .branch_is_taken_prediction_if_o (branch_is_taken_prediction_if_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'hABCD_0000 + addr;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit br, input logic [31:0] tgt, input bit ls, input bit ps);
        branching_i        = br;
        branch_target_i    = tgt;
        load_stall_i       = ls;
        peripheral_stall_i = ps;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] pred, input logic taken);
        exp_q.push_back('{instr: word_at(addr), pc: addr, pred_pc: pred, taken: taken});
    endtask

    // Memory answers at the negedge so a zero-wait ack lands in the same cycle as the request.
    initial begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        wait_cnt     = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i || !imem_req_o || !mem_en) begin
                imem_ack_i = 1'b0;
                wait_cnt   = 0;
            end else if (wait_cnt >= mem_wait) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = word_at(imem_addr_o);
                wait_cnt     = 0;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end
    end

    // An IF/ID load of a non-NOP word is a delivery and must match the queue head.
    initial begin
        bit   loaded;
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk_i);
            loaded = !rst_i && (branching_i || !(load_stall_i || peripheral_stall_i));
            #1;
            if (loaded && fetched_instruction_if_o != NOP) begin
                got = '{instr: fetched_instruction_if_o, pc: pc_if_o,
                        pred_pc: btb_predicted_pc_if_o, taken: branch_is_taken_prediction_if_o};
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected: got instr=0x%08h pc=0x%08h, expected no delivery",
                             got.instr, got.pc);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL sb_entry: got instr=0x%08h pc=0x%08h pred=0x%08h t=%0b, expected instr=0x%08h pc=0x%08h pred=0x%08h t=%0b",
                                 got.instr, got.pc, got.pred_pc, got.taken, e.instr, e.pc, e.pred_pc, e.taken);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        mem_en = 1'b1;
        mem_wait = 0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        btb_update_i = 1'b0;
        btb_update_pc_i = 32'h0;
        btb_update_target_i = 32'h0;
        btb_update_taken_i = 1'b0;
        tick();
        tick();

        // Reset state and zero-wait streaming
        checkOutput("rst_req", {31'h0, imem_req_o}, 32'h0);
        checkOutput("rst_pc_if", pc_if_o, 32'hFFFF_FFFC);
        checkOutput("rst_instr", fetched_instruction_if_o, NOP);
        checkOutput("rst_pred_pc", btb_predicted_pc_if_o, 32'h0);
        checkOutput("rst_pred_taken", {31'h0, branch_is_taken_prediction_if_o}, 32'h0);
        push_exp(32'h0, 32'h4, 1'b0);
        push_exp(32'h4, 32'h8, 1'b0);
        push_exp(32'h8, 32'hC, 1'b0);
        push_exp(32'hC, 32'h10, 1'b0);
        rst_i = 1'b0;
        #1;
        checkOutput("seq_req", {31'h0, imem_req_o}, 32'h1);
        checkOutput("seq_addr0", imem_addr_o, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput("seq_addr", imem_addr_o, 32'(4 * k));
            checkOutput("seq_pc_trail", pc_if_o, 32'(4 * (k - 1)));
        end

        // Stall at the ack of 0x10
        push_exp(32'h10, 32'h14, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold_req", {31'h0, imem_req_o}, 32'h0);
            checkOutput("hold_pc_if", pc_if_o, 32'hC);
            checkOutput("hold_instr", fetched_instruction_if_o, word_at(32'hC));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("hold_release_pc", pc_if_o, 32'h10);
        checkOutput("hold_release_addr", imem_addr_o, 32'h14);

        // Two wait states per access
        mem_wait = 2;
        push_exp(32'h14, 32'h18, 1'b0);
        push_exp(32'h18, 32'h1C, 1'b0);
        push_exp(32'h1C, 32'h20, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 2; b++) begin
                tick();
                checkOutput("ws_bubble", fetched_instruction_if_o, NOP);
                checkOutput("ws_addr_stable", imem_addr_o, 32'(32'h14 + 4 * k));
            end
            tick();
            checkOutput("ws_pc_if", pc_if_o, 32'(32'h14 + 4 * k));
        end

        // Redirect while 0x20 is outstanding and unacked
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("redir_nop", fetched_instruction_if_o, NOP);
        checkOutput("redir_taken", {31'h0, branch_is_taken_prediction_if_o}, 32'h0);
        checkOutput("redir_req", {31'h0, imem_req_o}, 32'h1);
        checkOutput("redir_addr_held", imem_addr_o, 32'h20);
        tick();
        checkOutput("redir_addr_held2", imem_addr_o, 32'h20);
        tick();
        checkOutput("redir_dropped", fetched_instruction_if_o, NOP);
        checkOutput("redir_target_addr", imem_addr_o, 32'h200);
        mem_wait = 0;
        push_exp(32'h200, 32'h204, 1'b0);
        tick();
        checkOutput("redir_target_pc", pc_if_o, 32'h200);

        // BTB training on 0x40
        mem_en = 1'b0;
        btb_update_i = 1'b1;
        btb_update_pc_i = 32'h40;
        btb_update_target_i = 32'h100;
        btb_update_taken_i = 1'b1;
        tick();
        btb_update_i = 1'b0;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        mem_en = 1'b1;
        push_exp(32'h40, 32'h100, 1'b1);
        tick();
        checkOutput("btb_fetch_addr", imem_addr_o, 32'h40);
        tick();
        checkOutput("btb_next_addr", imem_addr_o, 32'h100);
        checkOutput("btb_pred_taken", {31'h0, branch_is_taken_prediction_if_o}, 32'h1);
        checkOutput("btb_pred_pc", btb_predicted_pc_if_o, 32'h100);
        mem_en = 1'b0;
        btb_update_i = 1'b1;
        btb_update_taken_i = 1'b0;
        btb_update_target_i = 32'h0;
        tick();
        tick();
        btb_update_i = 1'b0;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        mem_en = 1'b1;
        push_exp(32'h40, 32'h44, 1'b0);
        tick();
        tick();
        checkOutput("btb_fallthrough_addr", imem_addr_o, 32'h44);
        checkOutput("btb_fallthrough_pred", btb_predicted_pc_if_o, 32'h44);

        // Redirect while holding a buffered word: the buffer must be dropped
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("sim_hold_req", {31'h0, imem_req_o}, 32'h0);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("sim_hold_nop", fetched_instruction_if_o, NOP);
        checkOutput("sim_hold_addr", imem_addr_o, 32'h300);
        push_exp(32'h300, 32'h304, 1'b0);
        tick();
        checkOutput("sim_hold_next", imem_addr_o, 32'h304);

        // Redirect, stall and ack in the same cycle
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("sim_all_nop", fetched_instruction_if_o, NOP);
        checkOutput("sim_all_addr", imem_addr_o, 32'h400);
        checkOutput("sim_all_req", {31'h0, imem_req_o}, 32'h1);
        push_exp(32'h400, 32'h404, 1'b0);
        tick();
        mem_en = 1'b0;
        tick();

        // Reset while a request is outstanding
        rst_i = 1'b1;
        #1;
        checkOutput("rst_mid_req", {31'h0, imem_req_o}, 32'h0);
        tick();
        checkOutput("rst_mid_pc_if", pc_if_o, 32'hFFFF_FFFC);
        checkOutput("rst_mid_instr", fetched_instruction_if_o, NOP);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_mid_restart", imem_addr_o, 32'h0);
        tick();
        tick();

        checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the 5-stage RV32I core: the producer side of the IF/ID pipeline register that instruction decode consumes. Issues one-outstanding requests on the instruction-memory bus and predicts the next PC with a direct-mapped BTB of 2-bit counters. Registers instruction, PC and prediction to decode, and honours decode stalls and execute-stage redirects.

## Interface
- BTB_ENTRIES, 16: BTB entry count, power of two, at least 2; IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- imem_req_o  out  1  request valid; held with a stable address until ack
- imem_addr_o  out  32  fetch address, word aligned
- imem_ack_i  in  1  request complete; may be high in the same cycle as the request
- imem_rdata_i  in  32  instruction word, valid with ack
- load_stall_i  in  1  decode load-use stall: hold IF/ID
- peripheral_stall_i  in  1  peripheral stall: hold IF/ID
- branching_i  in  1  redirect or mispredict from execute
- branch_target_i  in  32  redirect PC
- btb_update_i  in  1  resolved control-flow instruction
- btb_update_pc_i  in  32  PC of the resolved instruction
- btb_update_target_i  in  32  its resolved target
- btb_update_taken_i  in  1  its resolved direction
- fetched_instruction_if_o  out  32  IF/ID instruction
- pc_if_o  out  32  IF/ID PC
- btb_predicted_pc_if_o  out  32  predicted next PC for that instruction
- branch_is_taken_prediction_if_o  out  1  prediction bit

## Operation
- stall = load_stall_i | peripheral_stall_i. Priority order: rst_i, then branching_i, then stall.
- FSM states: FETCH, HOLD, DISCARD. The reset state is FETCH.
- **FETCH**
  - imem_req_o = 1 and imem_addr_o = fetch_pc.
  - On ack with no stall: IF/ID takes {rdata, fetch_pc, pred_pc, pred_taken}; fetch_pc ← pred_pc.
  - On ack with stall: latch the word and prediction into the hold buffer; fetch_pc ← pred_pc; go to HOLD.
  - No ack and no stall: IF/ID takes a bubble, NOP 32'h0000_0013 with prediction 0 and PC unchanged.
- **HOLD**
  - imem_req_o = 0.
  - When stall drops, IF/ID takes the buffer and the FSM returns to FETCH.
- **DISCARD**
  - imem_req_o = 1 and the address is held at its old value.
  - On ack, the data is dropped and the FSM goes to FETCH.
- **Stall:** IF/ID holds its value in every state.
- **branching_i**
  - IF/ID ← NOP with prediction 0, and fetch_pc ← branch_target_i. The hold buffer is invalidated.
  - The FSM goes to DISCARD only if a request is outstanding and imem_ack_i = 0 in that cycle; otherwise it goes to FETCH.
- **BTB fields**
  - index = pc[IDX+1:2]; tag = pc[31:IDX+2].
  - Entry = {valid, tag, target[31:0], ctr[1:0]}.
- **BTB lookup** is combinational on fetch_pc.
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_pc = pred_taken ? target : fetch_pc + 4, computed modulo 2^32.
- **BTB update**, registered on btb_update_i:
  - On hit: ctr saturates up when taken, down when not taken, and target is rewritten when taken.
  - On miss with taken: allocate with ctr = 2'b10.
  - On miss with not taken: no write.
- **Reset values**
  - fetch_pc = RESET_PC; IF/ID instruction = 32'h0000_0013; pc_if_o = 32'hFFFF_FFFC.
  - btb_predicted_pc_if_o = 0; prediction = 0.
  - All BTB valid bits = 0; hold buffer empty.
  - Reset mid-request abandons the request immediately (imem_req_o = 0 while rst_i is high).

## Timing
- With a same-cycle ack, throughput is 1 instruction per cycle and latency is 1 cycle from imem_addr_o to IF/ID.
- With N wait cycles, N bubbles are inserted.
- Redirect:
  - The first request to the target is issued the cycle after branching_i, or the cycle after the discarded ack.
  - No stale instruction ever reaches IF/ID after branching_i.
- An update and a lookup to the same index in the same cycle: the lookup sees the old entry.
- An update whose tag differs from the current entry overwrites it (allocate-on-taken replacement).
- imem_addr_o must not change while imem_req_o = 1 and ack is low.

## Test plan
- **Reset sequence:** assert reset, release it, zero-wait memory returning the instruction at each PC. Expect imem_addr_o 0x0, 0x4, 0x8 on consecutive cycles, and pc_if_o to trail imem_addr_o by one cycle.
- **Wait-state memory:** two-cycle ack latency. Expect imem_addr_o stable through the wait and 2 NOP bubbles per instruction in IF/ID.
- **Stall at ack:** load_stall_i for 3 cycles at the ack of 0x10. Expect IF/ID to keep 0x0C, the FSM in HOLD with imem_req_o = 0, and 0x10 delivered the cycle after the stall drops, with no loss or duplication.
- **Redirect with outstanding request:** branching_i to 0x200 while a request to 0x20 is outstanding and unacked. Expect IF/ID = NOP, address 0x20 held until ack, the word dropped, and the next request at 0x200.
- **BTB training:** update pc 0x40 taken to 0x100, then refetch 0x40. Expect pred_taken = 1, next imem_addr_o = 0x100, and btb_predicted_pc_if_o = 0x100. Then two not-taken updates: expect a fall-through prediction to 0x44.
- **Simultaneous events:** branching_i together with stall and ack. Expect the redirect to win and the HOLD buffer to be dropped.
